// File: rtl/tilelink_ram_pipe_pkg.sv
// Bus payload types and opcode encodings for the TileLink-UL slave RAM.
package tilelink_ram_pipe_pkg;

    localparam int unsigned SRC_W = 8;

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_ACK         = 3'd0;
    localparam logic [2:0] OP_ACK_DATA    = 3'd1;

    typedef struct packed {
        logic [2:0]       a_opcode;
        logic [2:0]       a_size;
        logic [SRC_W-1:0] a_source;
        logic [31:0]      a_address;
        logic [3:0]       a_mask;
        logic [31:0]      a_data;
        logic             a_valid;
    } tilelink_a;

    typedef struct packed {
        logic [2:0]       d_opcode;
        logic [1:0]       d_param;
        logic [2:0]       d_size;
        logic [SRC_W-1:0] d_source;
        logic             d_sink;
        logic [31:0]      d_data;
        logic             d_error;
        logic             d_valid;
        logic             d_ready;
    } tilelink_d;

    // One queued response beat; param and sink are always zero so not stored.
    typedef struct packed {
        logic [2:0]       opcode;
        logic [2:0]       size;
        logic [SRC_W-1:0] source;
        logic             error;
        logic [31:0]      data;
    } rsp_t;

endpackage

// File: rtl/tilelink_ram_pipe.sv
// TileLink-UL slave RAM with 1- or 2-stage read pipeline, credit-tracked
// response queue and error responses for illegal requests.
module tilelink_ram_pipe
    import tilelink_ram_pipe_pkg::*;
#(
    parameter logic [31:0] addr_mask    = 32'hF000_0000,
    parameter logic [31:0] addr_tag     = 32'h0000_0000,
    parameter int unsigned depth_words  = 16384,
    parameter int unsigned read_latency = 1,
    parameter int unsigned rsp_depth    = 2,
    parameter string       filename     = ""
) (
    input  logic      clock,
    input  logic      reset_n,
    input  tilelink_a tick_tla,
    input  logic      host_d_ready,
    output tilelink_d bus_tld
);

    localparam int unsigned IDX_W = $clog2(depth_words);
    localparam int unsigned CRD_W = $clog2(rsp_depth + 1);

    logic [31:0]          r_mem [depth_words];
    rsp_t                 r_s1;
    logic                 r_s1_vld;
    rsp_t                 r_q [rsp_depth];
    logic [rsp_depth-1:0] r_q_vld;
    logic [CRD_W-1:0]     r_cnt;
    logic [CRD_W-1:0]     r_credits;
    logic                 r_d_ready;

    logic                 w_sel;
    logic                 w_accept;
    logic                 w_get;
    logic                 w_put;
    logic                 w_aligned;
    logic                 w_legal;
    logic [IDX_W-1:0]     w_idx;
    rsp_t                 w_meta;
    rsp_t                 w_tail;
    logic                 w_push;
    logic                 w_pop;
    logic [CRD_W-1:0]     w_slot;
    logic [CRD_W-1:0]     w_credits_n;
    rsp_t                 w_q_n [rsp_depth];
    logic [rsp_depth-1:0] w_q_vld_n;

    // Request decode and response metadata.
    always_comb begin
        w_sel    = tick_tla.a_valid && ((tick_tla.a_address & addr_mask) == addr_tag);
        w_accept = w_sel && r_d_ready;
        w_get    = (tick_tla.a_opcode == OP_GET);
        w_put    = (tick_tla.a_opcode == OP_PUT_FULL) || (tick_tla.a_opcode == OP_PUT_PARTIAL);
        case (tick_tla.a_size)
            3'd0:    w_aligned = 1'b1;
            3'd1:    w_aligned = !tick_tla.a_address[0];
            3'd2:    w_aligned = (tick_tla.a_address[1:0] == 2'b00);
            default: w_aligned = 1'b0;
        endcase
        w_legal       = (w_get || w_put) && w_aligned;
        w_idx         = tick_tla.a_address[IDX_W+1:2];
        w_meta        = '0;
        w_meta.opcode = w_get ? OP_ACK_DATA : OP_ACK;
        w_meta.size   = tick_tla.a_size;
        w_meta.source = tick_tla.a_source;
        w_meta.error  = !w_legal;
    end

    // RAM array and first pipeline payload; RAM contents survive reset.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_s1 <= w_meta;
            if (w_get && w_legal) begin
                r_s1.data <= r_mem[w_idx];
            end
            if (w_put && w_legal) begin
                for (int b = 0; b < 4; b++) begin
                    if (tick_tla.a_mask[b]) begin
                        r_mem[w_idx][8*b +: 8] <= tick_tla.a_data[8*b +: 8];
                    end
                end
            end
        end
    end

    if (read_latency == 2) begin : g_lat2
        rsp_t r_s2;
        logic r_s2_vld;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_s2_vld <= 1'b0;
            end else begin
                r_s2_vld <= r_s1_vld;
            end
        end

        always_ff @(posedge clock) begin
            r_s2 <= r_s1;
        end

        assign w_tail = r_s2;
        assign w_push = r_s2_vld;
    end else begin : g_lat1
        assign w_tail = r_s1;
        assign w_push = r_s1_vld;
    end

    // Shift-register response queue: entry 0 is the head, empty entries hold zero.
    always_comb begin
        w_pop     = r_q_vld[0] && host_d_ready;
        w_q_n     = r_q;
        w_q_vld_n = r_q_vld;
        w_slot    = r_cnt - CRD_W'(w_pop);
        if (w_pop) begin
            for (int i = 0; i < int'(rsp_depth) - 1; i++) begin
                w_q_n[i]     = r_q[i+1];
                w_q_vld_n[i] = r_q_vld[i+1];
            end
            w_q_n[rsp_depth-1]     = '0;
            w_q_vld_n[rsp_depth-1] = 1'b0;
        end
        if (w_push) begin
            for (int i = 0; i < int'(rsp_depth); i++) begin
                if (CRD_W'(i) == w_slot) begin
                    w_q_n[i]     = w_tail;
                    w_q_vld_n[i] = 1'b1;
                end
            end
        end
        w_credits_n = r_credits + CRD_W'(w_accept) - CRD_W'(w_pop);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_vld <= 1'b0;
            for (int i = 0; i < int'(rsp_depth); i++) begin
                r_q[i] <= '0;
            end
            r_q_vld   <= '0;
            r_cnt     <= '0;
            r_credits <= '0;
            r_d_ready <= 1'b0;
        end else begin
            r_s1_vld  <= w_accept;
            r_q       <= w_q_n;
            r_q_vld   <= w_q_vld_n;
            r_cnt     <= r_cnt + CRD_W'(w_push) - CRD_W'(w_pop);
            r_credits <= w_credits_n;
            r_d_ready <= (w_credits_n < CRD_W'(rsp_depth));
        end
    end

    always_comb begin
        bus_tld          = '0;
        bus_tld.d_opcode = r_q[0].opcode;
        bus_tld.d_size   = r_q[0].size;
        bus_tld.d_source = r_q[0].source;
        bus_tld.d_data   = r_q[0].data;
        bus_tld.d_error  = r_q[0].error;
        bus_tld.d_valid  = r_q_vld[0];
        bus_tld.d_ready  = r_d_ready;
    end

endmodule

// File: tb/tb_tilelink_ram_pipe.sv
// Scoreboard bench for tilelink_ram_pipe: latency-1 default instance and a
// latency-2, 1024-word instance exercised by the same sequence in turn.
module tb_tilelink_ram_pipe;
    import tilelink_ram_pipe_pkg::*;

    logic      clock   = 1'b0;
    logic      reset_n = 1'b1;
    logic      hrdy    = 1'b1;
    int        cur     = 0;
    tilelink_a tb_a    = '0;
    tilelink_a a0, a1;
    tilelink_d d0, d1, d_cur;

    int          n_chk   = 0;
    int          n_bad   = 0;
    int          acc_cnt = 0;
    logic [63:0] exp_q[$];

    always #5 clock = ~clock;

    assign a0    = (cur == 0) ? tb_a : '0;
    assign a1    = (cur == 1) ? tb_a : '0;
    assign d_cur = (cur == 0) ? d0 : d1;

    tilelink_ram_pipe #(.read_latency(1)) dut0 (
        .clock(clock), .reset_n(reset_n), .tick_tla(a0), .host_d_ready(hrdy), .bus_tld(d0)
    );

    tilelink_ram_pipe #(.read_latency(2), .depth_words(1024)) dut1 (
        .clock(clock), .reset_n(reset_n), .tick_tla(a1), .host_d_ready(hrdy), .bus_tld(d1)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s (dut%0d): got %h want %h", tag, cur, obs, exp);
        end
    endtask

    function automatic logic [63:0] rsp(input logic [2:0] op, input logic [2:0] sz,
                                        input logic [7:0] src, input logic err,
                                        input logic [31:0] data);
        return 64'({op, 2'b00, sz, src, 1'b0, err, data});
    endfunction

    function automatic logic [63:0] pack_d(input tilelink_d d);
        return 64'({d.d_opcode, d.d_param, d.d_size, d.d_source, d.d_sink, d.d_error, d.d_data});
    endfunction

    // Every valid beat is compared with the scoreboard head; popped when the host takes it.
    always @(negedge clock) begin
        if (reset_n && d_cur.d_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_rsp", 64'(d_cur.d_valid), 64'd0);
            end else begin
                check_eq(hrdy ? "rsp" : "rsp_hold", pack_d(d_cur), exp_q[0]);
                if (hrdy) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [2:0] sz, input logic [7:0] src,
                        input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                        input bit sel, input logic [63:0] exp);
        int n = 0;
        tb_a.a_opcode  = op;
        tb_a.a_size    = sz;
        tb_a.a_source  = src;
        tb_a.a_address = addr;
        tb_a.a_mask    = mask;
        tb_a.a_data    = data;
        tb_a.a_valid   = 1'b1;
        if (sel) begin
            while (!d_cur.d_ready && n < 60) begin
                tick();
                n++;
            end
            check_eq("accept_rdy", 64'(d_cur.d_ready), 64'd1);
            if (d_cur.d_ready) exp_q.push_back(exp);
        end
        tick();
        tb_a.a_valid = 1'b0;
        if (sel) acc_cnt++;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check_eq("drain", 64'(exp_q.size()), 64'd0);
        tick();
        check_eq("idle", 64'({d_cur.d_valid, d_cur.d_error}), 64'd0);
    endtask

    task automatic do_reset();
        tb_a    = '0;
        hrdy    = 1'b1;
        reset_n = 1'b0;
        tick();
        tick();
        check_eq("rst_out", 64'({d_cur.d_valid, d_cur.d_error, d_cur.d_ready}), 64'd0);
        exp_q.delete();
        reset_n = 1'b1;
        tick();
        check_eq("rst_rdy", 64'(d_cur.d_ready), 64'd1);
    endtask

    task automatic run_suite(input int k);
        int n;
        logic [31:0] bp_data [4];
        do_reset();

        // Put then immediate Get (same-word hazard), partial write, re-read.
        send(OP_PUT_FULL,    3'd2, 8'd3, 32'h10, 4'hF,    32'hDEADBEEF, 1, rsp(OP_ACK, 3'd2, 8'd3, 1'b0, 32'h0));
        send(OP_GET,         3'd2, 8'd4, 32'h10, 4'hF,    32'h0,        1, rsp(OP_ACK_DATA, 3'd2, 8'd4, 1'b0, 32'hDEADBEEF));
        send(OP_PUT_PARTIAL, 3'd2, 8'd5, 32'h10, 4'b0100, 32'h00AA0000, 1, rsp(OP_ACK, 3'd2, 8'd5, 1'b0, 32'h0));
        send(OP_GET,         3'd2, 8'd6, 32'h10, 4'hF,    32'h0,        1, rsp(OP_ACK_DATA, 3'd2, 8'd6, 1'b0, 32'hDEAABEEF));
        wait_drain();

        // Latency from acceptance to d_valid, then a byte-sized Get.
        send(OP_GET, 3'd2, 8'd7, 32'h10, 4'hF, 32'h0, 1, rsp(OP_ACK_DATA, 3'd2, 8'd7, 1'b0, 32'hDEAABEEF));
        n = 0;
        while (!d_cur.d_valid && n < 10) begin
            tick();
            n++;
        end
        check_eq("latency", 64'(n), 64'(k + 1));
        send(OP_GET, 3'd0, 8'd8, 32'h12, 4'hF, 32'h0, 1, rsp(OP_ACK_DATA, 3'd0, 8'd8, 1'b0, 32'hDEAABEEF));
        wait_drain();

        // Backpressure: four Gets with the host stalled.
        for (int i = 0; i < 4; i++) begin
            bp_data[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
            send(OP_PUT_FULL, 3'd2, 8'(16 + i), 32'h20 + 32'(4 * i), 4'hF, bp_data[i], 1,
                 rsp(OP_ACK, 3'd2, 8'(16 + i), 1'b0, 32'h0));
        end
        wait_drain();
        hrdy    = 1'b0;
        acc_cnt = 0;
        fork
            for (int i = 0; i < 4; i++) begin
                send(OP_GET, 3'd2, 8'(20 + i), 32'h20 + 32'(4 * i), 4'hF, 32'h0, 1,
                     rsp(OP_ACK_DATA, 3'd2, 8'(20 + i), 1'b0, bp_data[i]));
            end
            begin
                int m = 0;
                while (acc_cnt < 2 && m < 100) begin
                    @(negedge clock);
                    m++;
                end
                check_eq("bp_rdy_low", 64'(d_cur.d_ready), 64'd0);
                check_eq("bp_accepts", 64'(acc_cnt), 64'd2);
                repeat (3) @(negedge clock);
                check_eq("bp_valid", 64'(d_cur.d_valid), 64'd1);
                tick();
                hrdy = 1'b1;
            end
        join
        wait_drain();

        // Illegal requests: error responses, memory untouched.
        send(OP_GET,      3'd3, 8'd30, 32'h10, 4'hF, 32'h0,        1, rsp(OP_ACK_DATA, 3'd3, 8'd30, 1'b1, 32'h0));
        send(OP_GET,      3'd2, 8'd31, 32'h02, 4'hF, 32'h0,        1, rsp(OP_ACK_DATA, 3'd2, 8'd31, 1'b1, 32'h0));
        send(3'd2,        3'd2, 8'd32, 32'h10, 4'hF, 32'hFFFFFFFF, 1, rsp(OP_ACK, 3'd2, 8'd32, 1'b1, 32'h0));
        send(OP_PUT_FULL, 3'd3, 8'd33, 32'h10, 4'hF, 32'hFFFFFFFF, 1, rsp(OP_ACK, 3'd3, 8'd33, 1'b1, 32'h0));
        send(OP_PUT_FULL, 3'd1, 8'd34, 32'h11, 4'hF, 32'hFFFFFFFF, 1, rsp(OP_ACK, 3'd1, 8'd34, 1'b1, 32'h0));
        send(OP_GET,      3'd2, 8'd35, 32'h10, 4'hF, 32'h0,        1, rsp(OP_ACK_DATA, 3'd2, 8'd35, 1'b0, 32'hDEAABEEF));

        // Unselected address: ignored, no response, RAM unchanged.
        send(OP_PUT_FULL, 3'd2, 8'd36, 32'h1000_0010, 4'hF, 32'h12345678, 0, 64'd0);
        send(OP_GET,      3'd2, 8'd37, 32'h1000_0010, 4'hF, 32'h0,        0, 64'd0);
        send(OP_GET,      3'd2, 8'd38, 32'h10,        4'hF, 32'h0,        1, rsp(OP_ACK_DATA, 3'd2, 8'd38, 1'b0, 32'hDEAABEEF));
        wait_drain();

        // Aliasing: 0x1000 maps to word 0 only in the 1024-word instance.
        send(OP_PUT_FULL, 3'd2, 8'd40, 32'h0,    4'hF, 32'hCAFEF00D, 1, rsp(OP_ACK, 3'd2, 8'd40, 1'b0, 32'h0));
        send(OP_PUT_FULL, 3'd2, 8'd41, 32'h1000, 4'hF, 32'h0BADC0DE, 1, rsp(OP_ACK, 3'd2, 8'd41, 1'b0, 32'h0));
        send(OP_GET,      3'd2, 8'd42, 32'h0,    4'hF, 32'h0,        1,
             rsp(OP_ACK_DATA, 3'd2, 8'd42, 1'b0, (k == 1) ? 32'h0BADC0DE : 32'hCAFEF00D));
        send(OP_GET,      3'd2, 8'd43, 32'h1000, 4'hF, 32'h0,        1, rsp(OP_ACK_DATA, 3'd2, 8'd43, 1'b0, 32'h0BADC0DE));
        wait_drain();

        // Reset with two responses queued.
        hrdy = 1'b0;
        send(OP_GET, 3'd2, 8'd50, 32'h10, 4'hF, 32'h0, 1, rsp(OP_ACK_DATA, 3'd2, 8'd50, 1'b0, 32'hDEAABEEF));
        send(OP_GET, 3'd2, 8'd51, 32'h20, 4'hF, 32'h0, 1, rsp(OP_ACK_DATA, 3'd2, 8'd51, 1'b0, bp_data[0]));
        n = 0;
        while (!d_cur.d_valid && n < 10) begin
            tick();
            n++;
        end
        check_eq("mid_pre_valid", 64'(d_cur.d_valid), 64'd1);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 64'({d_cur.d_valid, d_cur.d_error, d_cur.d_ready}), 64'd0);
        exp_q.delete();
        hrdy = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();
        check_eq("mid_rdy", 64'(d_cur.d_ready), 64'd1);
        repeat (4) tick();
        check_eq("mid_no_stale", 64'(d_cur.d_valid), 64'd0);
        send(OP_GET, 3'd2, 8'd52, 32'h10, 4'hF, 32'h0, 1, rsp(OP_ACK_DATA, 3'd2, 8'd52, 1'b0, 32'hDEAABEEF));
        wait_drain();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            cur = k;
            run_suite(k);
        end
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
